// File: rtl/dataflow_pkg.sv
// Shared types and helpers for the dataflow half-adder slice.
// Consumed by dataflow and half_adder_cell via import dataflow_pkg::*.
package dataflow_pkg;

    localparam int unsigned CNT_W_DEFAULT = 8;

    typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

    // All-ones value of a counter of the given width (1..32); the counter's saturation point.
    function automatic logic [31:0] sat_max(input int unsigned width);
        if (width >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Purely combinational 1-bit half adder: s = a ^ b, c = a & b.
module half_adder_cell
    import dataflow_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/dataflow.sv
// Half-adder cell with a one-cycle registered copy of sum/carry and an optional
// saturating carry-event counter, built only when DATAFLOW_CARRY_CNT_EN is defined.
module dataflow
    import dataflow_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    output logic             s,
    output logic             c,
    output logic             s_r,
    output logic             c_r,
    output logic [CNT_W-1:0] carry_cnt
);

    half_adder_cell u_cell (
        .a (a),
        .b (b),
        .s (s),
        .c (c)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_r <= 1'b0;
            c_r <= 1'b0;
        end else begin
            s_r <= s;
            c_r <= c;
        end
    end

`ifdef DATAFLOW_CARRY_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    logic [CNT_W-1:0] cnt_q;

    // Counts edges that saw a carry; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (c && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign carry_cnt = cnt_q;
`else
    assign carry_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_dataflow.sv
// Directed self-checking bench for dataflow (CNT_W = 2 to reach saturation quickly).
// Counter expectations follow DATAFLOW_CARRY_CNT_EN: counted values when defined, zero otherwise.
module tb_dataflow;

    localparam int unsigned CNT_W = 2;
`ifdef DATAFLOW_CARRY_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             a;
    logic             b;
    logic             s;
    logic             c;
    logic             s_r;
    logic             c_r;
    logic [CNT_W-1:0] carry_cnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    dataflow #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .s         (s),
        .c         (c),
        .s_r       (s_r),
        .c_r       (c_r),
        .carry_cnt (carry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive inputs, let one rising edge pass, return at the following falling edge.
    task automatic step(input logic na, input logic nb, input logic nrst);
        a   = na;
        b   = nb;
        rst = nrst;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] cnt_exp(input int unsigned v);
        return CNT_EN ? v : 32'd0;
    endfunction

    // Expected counter values while holding ab=11 from zero, saturating at 3.
    int unsigned sat_tbl [5] = '{1, 2, 3, 3, 3};
    // Truth table: {a,b} -> {s,c}
    logic [1:0] tt_in  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [1:0] tt_out [4] = '{2'b00, 2'b10, 2'b10, 2'b01};

    initial begin
        // Reset first: register contents are undefined before the first reset edge.
        step(1'b1, 1'b1, 1'b1);
        check("rst_s_r", 32'(s_r), 32'd0);
        check("rst_c_r", 32'(c_r), 32'd0);
        check("rst_cnt", 32'(carry_cnt), 32'd0);
        check("rst_c_comb", 32'(c), 32'd1);

        // Combinational sweep, 2 ns apart, while reset is still held.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] in_v;
            logic [1:0] out_v;
            in_v  = tt_in[i];
            out_v = tt_out[i];
            a = in_v[1];
            b = in_v[0];
            #1;
            check($sformatf("tt_s_%0d", i), 32'(s), 32'(out_v[1]));
            check($sformatf("tt_c_%0d", i), 32'(c), 32'(out_v[0]));
            #1;
        end
        @(negedge clk);

        // Registered latency: ab=00 captured, then ab=11.
        step(1'b0, 1'b0, 1'b0);
        check("lat00_s_r", 32'(s_r), 32'd0);
        check("lat00_c_r", 32'(c_r), 32'd0);
        a = 1'b1;
        b = 1'b1;
        #1;
        check("lat_pre_c_r", 32'(c_r), 32'd0);
        check("lat_pre_c", 32'(c), 32'd1);
        step(1'b1, 1'b1, 1'b0);
        check("lat11_s_r", 32'(s_r), 32'd0);
        check("lat11_c_r", 32'(c_r), 32'd1);
        check("lat11_cnt", 32'(carry_cnt), cnt_exp(1));

        // Carry absent: counter holds, sum registered.
        step(1'b0, 1'b1, 1'b0);
        check("hold_s_r", 32'(s_r), 32'd1);
        check("hold_c_r", 32'(c_r), 32'd0);
        check("hold_cnt", 32'(carry_cnt), cnt_exp(1));

        // Reset wins over capture and increment with ab=11.
        step(1'b1, 1'b1, 1'b1);
        check("prio_s_r", 32'(s_r), 32'd0);
        check("prio_c_r", 32'(c_r), 32'd0);
        check("prio_cnt", 32'(carry_cnt), 32'd0);
        check("prio_c", 32'(c), 32'd1);
        check("prio_s", 32'(s), 32'd0);

        // Saturation: hold ab=11 for five edges.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check($sformatf("sat_cnt_%0d", i), 32'(carry_cnt), cnt_exp(sat_tbl[i]));
            check($sformatf("sat_c_r_%0d", i), 32'(c_r), 32'd1);
            check($sformatf("sat_s_r_%0d", i), 32'(s_r), 32'd0);
        end

        // Reset mid-count: clear, count to 2, reset, then resume from 0.
        step(1'b0, 1'b0, 1'b1);
        check("mid_clr", 32'(carry_cnt), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("mid_two", 32'(carry_cnt), cnt_exp(2));
        step(1'b1, 1'b1, 1'b1);
        check("mid_rst", 32'(carry_cnt), 32'd0);
        check("mid_rst_c_r", 32'(c_r), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        check("mid_resume", 32'(carry_cnt), cnt_exp(1));
        check("mid_resume_c_r", 32'(c_r), 32'd1);

        // Single-operand patterns after reset release.
        step(1'b1, 1'b0, 1'b0);
        check("a1b0_s_r", 32'(s_r), 32'd1);
        check("a1b0_c_r", 32'(c_r), 32'd0);
        check("a1b0_cnt", 32'(carry_cnt), cnt_exp(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
